// File: rtl/mc_control_unit.sv
// Main-FSM controller for the multicycle RV32I datapath: fetch, decode, execute,
// memory and writeback sequencing, illegal-opcode trap and retired-instruction count.
module mc_control_unit #(
  parameter bit TRAP_ILLEGAL = 1'b1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             cout,
  input  logic             overflow,
  input  logic             sign,
  output logic [2:0]       imm_src,
  output logic [3:0]       alu_control,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             illegal_instr,
  output logic             retired,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_PC,
    S_LUI, S_AUIPC, S_ILLEGAL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       br_f3_ok;
  logic       unused_instr;

  assign op           = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7b5     = instr[30];
  assign br_f3_ok     = (funct3 != 3'b010) && (funct3 != 3'b011);
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BR:             state_d = br_f3_ok ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR_PC;
      S_JALR_PC:  state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_AUIPC:    state_d = S_ALUWB;
      S_ILLEGAL:  state_d = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // ALU operation for register and immediate arithmetic; SUB only exists in R-type
  logic [3:0] alu_arith;
  always_comb begin
    alu_arith = ALU_ADD;
    case (funct3)
      3'b000: alu_arith = (state_q == S_EXEC_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_arith = ALU_SLL;
      3'b010: alu_arith = ALU_SLT;
      3'b011: alu_arith = ALU_SLTU;
      3'b100: alu_arith = ALU_XOR;
      3'b101: alu_arith = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_arith = ALU_OR;
      3'b111: alu_arith = ALU_AND;
      default: alu_arith = ALU_ADD;
    endcase
  end

  logic taken;
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000: taken = zero;
      3'b001: taken = ~zero;
      3'b100: taken = sign ^ overflow;
      3'b101: taken = ~(sign ^ overflow);
      3'b110: taken = ~cout;
      3'b111: taken = cout;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_STORE:          imm_src = 3'b001;
      OP_BR:             imm_src = 3'b010;
      OP_JAL:            imm_src = 3'b011;
      OP_LUI, OP_AUIPC:  imm_src = 3'b100;
      default:           imm_src = 3'b000;
    endcase
  end

  // Per-state datapath controls before reset gating
  logic ir_w, pc_upd, br, reg_w, mem_w, ret;
  always_comb begin
    alu_control   = ALU_ADD;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    adr_src       = 1'b0;
    ir_w          = 1'b0;
    pc_upd        = 1'b0;
    br            = 1'b0;
    reg_w         = 1'b0;
    mem_w         = 1'b0;
    ret           = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_w       = 1'b1;
        pc_upd     = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        ret        = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        ret     = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = alu_arith;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_arith;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        ret   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        br          = 1'b1;
        ret         = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_upd    = 1'b1;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_JALR_PC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_upd    = 1'b1;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_w      = 1'b1;
        ret        = 1'b1;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_ILLEGAL: begin
        illegal_instr = 1'b1;
        ret           = ~TRAP_ILLEGAL;
      end
      default: ;
    endcase
  end

  // Reset suppresses every write so an aborted instruction leaves no side effects
  assign ir_write      = ir_w  & ~reset;
  assign pc_write      = (pc_upd | (br & taken)) & ~reset;
  assign reg_write     = reg_w & ~reset;
  assign mem_write     = mem_w & ~reset;
  assign retired       = ret   & ~reset;
  assign retired_count = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ret) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: an instruction-level model expands each
// instruction into its expected per-cycle control vector and is compared every cycle.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero, cout, overflow, sign;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic        adr_src, ir_write, pc_write, reg_write, mem_write, illegal_instr, retired;
  logic [31:0] retired_count;

  mc_control_unit #(.TRAP_ILLEGAL(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .zero(zero), .cout(cout), .overflow(overflow), .sign(sign),
    .imm_src(imm_src), .alu_control(alu_control),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .mem_write(mem_write),
    .illegal_instr(illegal_instr), .retired(retired), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  imm;
    logic [3:0]  alu;
    logic [1:0]  a, b, rs;
    logic        adr, irw, pcw, rw, mw, ill, ret;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;

  exp_t        exp_q[$];
  logic [31:0] m_cnt;
  logic [2:0]  m_imm;
  int          ill_hold = 0;
  int          n_cmp = 0, n_bad = 0;

  function automatic exp_t actual();
    exp_t e;
    e.imm = imm_src;   e.alu = alu_control; e.a = alu_src_a; e.b = alu_src_b;
    e.rs  = result_src; e.adr = adr_src;    e.irw = ir_write; e.pcw = pc_write;
    e.rw  = reg_write; e.mw = mem_write;    e.ill = illegal_instr; e.ret = retired;
    e.cnt = retired_count;
    return e;
  endfunction

  task automatic add(input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu,
                     input logic [1:0] rs, input logic adr, input logic irw, input logic pcw,
                     input logic rw, input logic mw, input logic ill, input logic ret);
    exp_t e;
    e.imm = m_imm; e.alu = alu; e.a = a; e.b = b; e.rs = rs; e.adr = adr;
    e.irw = irw; e.pcw = pcw; e.rw = rw; e.mw = mw; e.ill = ill; e.ret = ret;
    e.cnt = m_cnt;
    exp_q.push_back(e);
    if (ret) m_cnt = m_cnt + 1;
  endtask

  function automatic logic [3:0] arith_op(input bit is_r, input logic [2:0] f3, input logic b30);
    case (f3)
      3'd0: return (is_r && b30) ? SUB : ADD;
      3'd1: return SLL;
      3'd2: return SLT;
      3'd3: return SLTU;
      3'd4: return XOR_;
      3'd5: return b30 ? SRA : SRL;
      3'd6: return OR_;
      default: return AND_;
    endcase
  endfunction

  // Expected behaviour of one instruction given the two source operand values
  task automatic build(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
    logic [32:0] diff;
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          tk, br_ok;
    op = ins[6:0];
    f3 = ins[14:12];
    diff = {1'b0, rs1} + {1'b0, ~rs2} + 33'd1;
    zero = (diff[31:0] == 32'd0);
    cout = diff[32];
    sign = diff[31];
    overflow = (rs1[31] != rs2[31]) && (diff[31] != rs1[31]);
    case (f3)
      3'd0: tk = (rs1 == rs2);
      3'd1: tk = (rs1 != rs2);
      3'd4: tk = ($signed(rs1) <  $signed(rs2));
      3'd5: tk = ($signed(rs1) >= $signed(rs2));
      3'd6: tk = (rs1 <  rs2);
      3'd7: tk = (rs1 >= rs2);
      default: tk = 1'b0;
    endcase
    br_ok = (f3 != 3'd2) && (f3 != 3'd3);
    case (op)
      7'h23: m_imm = 3'b001;
      7'h63: m_imm = 3'b010;
      7'h6F: m_imm = 3'b011;
      7'h37, 7'h17: m_imm = 3'b100;
      default: m_imm = 3'b000;
    endcase
    add(2'd0, 2'd2, ADD, 2'd2, 0, 1, 1, 0, 0, 0, 0);  // fetch
    add(2'd1, 2'd1, ADD, 2'd0, 0, 0, 0, 0, 0, 0, 0);  // decode
    case (op)
      7'h33: begin
        add(2'd2, 2'd0, arith_op(1, f3, ins[30]), 2'd0, 0, 0, 0, 0, 0, 0, 0);
        add(2'd0, 2'd0, ADD, 2'd0, 0, 0, 0, 1, 0, 0, 1);
      end
      7'h13: begin
        add(2'd2, 2'd1, arith_op(0, f3, ins[30]), 2'd0, 0, 0, 0, 0, 0, 0, 0);
        add(2'd0, 2'd0, ADD, 2'd0, 0, 0, 0, 1, 0, 0, 1);
      end
      7'h03: begin
        add(2'd2, 2'd1, ADD, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        add(2'd0, 2'd0, ADD, 2'd0, 1, 0, 0, 0, 0, 0, 0);
        add(2'd0, 2'd0, ADD, 2'd1, 0, 0, 0, 1, 0, 0, 1);
      end
      7'h23: begin
        add(2'd2, 2'd1, ADD, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        add(2'd0, 2'd0, ADD, 2'd0, 1, 0, 0, 0, 1, 0, 1);
      end
      7'h6F: begin
        add(2'd1, 2'd2, ADD, 2'd0, 0, 0, 1, 0, 0, 0, 0);
        add(2'd0, 2'd0, ADD, 2'd0, 0, 0, 0, 1, 0, 0, 1);
      end
      7'h67: begin
        add(2'd2, 2'd1, ADD, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        add(2'd1, 2'd2, ADD, 2'd0, 0, 0, 1, 0, 0, 0, 0);
        add(2'd0, 2'd0, ADD, 2'd0, 0, 0, 0, 1, 0, 0, 1);
      end
      7'h37: add(2'd0, 2'd0, ADD, 2'd3, 0, 0, 0, 1, 0, 0, 1);
      7'h17: begin
        add(2'd1, 2'd1, ADD, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        add(2'd0, 2'd0, ADD, 2'd0, 0, 0, 0, 1, 0, 0, 1);
      end
      default: begin
        if (op == 7'h63 && br_ok)
          add(2'd2, 2'd0, SUB, 2'd0, 0, 0, tk, 0, 0, 0, 1);
        else
          for (int i = 0; i < ill_hold; i++) add(2'd0, 2'd0, ADD, 2'd0, 0, 0, 0, 0, 0, 1, 0);
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Run one instruction from FETCH; stop_after>0 aborts after that many cycles
  task automatic run(input string name, input logic [31:0] ins, input logic [31:0] rs1,
                     input logic [31:0] rs2, input int cpi, input int stop_after);
    int   n, ret_at;
    exp_t e, g;
    exp_q.delete();
    instr = ins;
    build(ins, rs1, rs2);
    n = (stop_after > 0) ? stop_after : exp_q.size();
    ret_at = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      g = actual();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s cyc%0d: got %h want %h", name, k, g, e);
      end
      if (retired === 1'b1 && ret_at < 0) ret_at = k + 1;
      @(posedge clk); #1;
    end
    if (stop_after == 0) chk({name, "_cpi"}, ret_at, cpi);
    exp_q.delete();
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk("rst_enables", {27'd0, ir_write, pc_write, reg_write, mem_write, retired}, 32'd0);
      @(posedge clk); #1;
    end
    chk("rst_count", retired_count, 32'd0);
    reset = 1'b0;
    m_cnt = 32'd0;
  endtask

  initial begin
    reset = 1'b1; instr = 32'd0; zero = 0; cout = 0; overflow = 0; sign = 0; m_cnt = 0;
    @(posedge clk); #1;
    do_reset(2);

    run("add",   32'h002081B3, 32'd7, 32'd9, 4, 0);
    chk("add_count", retired_count, 32'd1);
    run("sub",   32'h402081B3, 32'd7, 32'd9, 4, 0);
    run("sra",   32'h4020D1B3, 32'd7, 32'd9, 4, 0);
    run("addi",  32'h40008193, 32'd1, 32'd2, 4, 0);
    run("srai",  32'h4030D193, 32'd1, 32'd2, 4, 0);
    run("andi",  32'h0020F193, 32'd1, 32'd2, 4, 0);
    run("sltiu", 32'h0020B193, 32'd1, 32'd2, 4, 0);
    run("lw",    32'h0000A183, 32'd4, 32'd0, 5, 0);
    run("sw",    32'h0030A023, 32'd4, 32'd0, 4, 0);
    run("beq",   32'h00208063, 32'd5, 32'd5, 3, 0);
    run("bltu",  32'h0020E063, 32'd9, 32'd3, 3, 0);
    run("blt",   32'h0020C063, 32'h80000000, 32'd1, 3, 0);
    run("bge",   32'h0020D063, 32'h80000000, 32'd1, 3, 0);
    run("bne",   32'h00209063, 32'd5, 32'd5, 3, 0);
    run("bgeu",  32'h0020F063, 32'd1, 32'd2, 3, 0);
    run("jal",   32'h0000006F, 32'd0, 32'd0, 4, 0);
    run("jalr",  32'h000280E7, 32'd0, 32'd0, 5, 0);
    run("lui",   32'h000011B7, 32'd0, 32'd0, 3, 0);
    run("auipc", 32'h00001197, 32'd0, 32'd0, 4, 0);
    chk("count19", retired_count, 32'd19);

    // abort a store in MEMWRITE
    run("sw_abort", 32'h0030A023, 32'd4, 32'd0, 4, 3);
    do_reset(1);
    run("add_after_abort", 32'h002081B3, 32'd1, 32'd1, 4, 0);
    chk("abort_count", retired_count, 32'd1);

    ill_hold = 20;
    run("op7f", 32'h0000007F, 32'd0, 32'd0, -1, 0);
    chk("op7f_held", {31'd0, illegal_instr}, 32'd1);
    do_reset(1);
    run("add_after_ill", 32'h002081B3, 32'd3, 32'd2, 4, 0);

    ill_hold = 3;
    run("br_f3_010", 32'h0020A063, 32'd3, 32'd3, -1, 0);
    do_reset(1);
    run("lui_end", 32'h000011B7, 32'd0, 32'd0, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
